// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scanner: hex segment table,
// the dark pattern and the digit count.
package seg_pkg;

  localparam int DIGITS = 8;
  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Active-low {dp,g,f,e,d,c,b,a}; entry n sits at HEX_TABLE[n].
  localparam logic [15:0][7:0] HEX_TABLE = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  typedef struct packed {
    logic [7:0] seg;
    logic [7:0] sel;
  } frame_t;

endpackage

// File: rtl/seg_decode.sv
// Combinational hex-to-segment decoder for one digit (active-low outputs).
import seg_pkg::*;

module seg_decode (
  input  logic [3:0] nibble,
  input  logic       dp,
  input  logic       blank,
  output logic [7:0] pattern
);

  // Look up the glyph, clear bit 7 for the decimal point, or go dark.
  always_comb begin
    pattern = SEG_OFF;
    if (blank) begin
      pattern = SEG_OFF;
    end else begin
      pattern = HEX_TABLE[nibble] & {~dp, 7'h7F};
    end
  end

endmodule

// File: rtl/seg_scan.sv
// Multiplexed 8-digit seven-segment scanner feeding an HC595 serializer.
// Optional leading-zero suppression: define SEG_SCAN_ZERO_BLANK_EN.
import seg_pkg::*;

module seg_scan #(
  parameter int SCAN_DIV = 50000,
  parameter int DIGITS   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data,
  input  logic [7:0]  dp,
  input  logic [7:0]  blank,
  input  logic        out_ready,
  output logic [7:0]  seg,
  output logic [7:0]  sel,
  output logic        out_valid,
  output logic        overrun
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(DIGITS);

  logic [CW-1:0] cnt_r;
  logic [IW-1:0] idx_r;
  logic [31:0]   data_sh_r;
  logic [7:0]    dp_sh_r;
  logic [7:0]    blank_sh_r;
  frame_t        frame_r;
  logic          out_valid_r;
  logic          overrun_r;

  logic          tick_s;
  logic          xfer_s;
  logic          load_s;
  logic [31:0]   frame_data_s;
  logic [7:0]    frame_dp_s;
  logic [7:0]    frame_blank_s;
  logic [7:0]    zb_s;
  logic [7:0]    pattern_s;

  assign tick_s = (cnt_r == CW'(SCAN_DIV - 1));
  assign xfer_s = out_valid_r & out_ready;
  assign load_s = tick_s & (~out_valid_r | xfer_s);

  // Digit 0 decodes straight from the live inputs it is about to capture.
  assign frame_data_s  = (idx_r == '0) ? data  : data_sh_r;
  assign frame_dp_s    = (idx_r == '0) ? dp    : dp_sh_r;
  assign frame_blank_s = (idx_r == '0) ? blank : blank_sh_r;

`ifdef SEG_SCAN_ZERO_BLANK_EN
  logic run_s;

  // Walk down from the top digit while nibbles are zero without a decimal point.
  always_comb begin
    zb_s  = 8'h00;
    run_s = 1'b1;
    for (int i = 7; i >= 1; i--) begin
      if (run_s && (frame_data_s[4*i +: 4] == 4'h0) && !frame_dp_s[i]) begin
        zb_s[i] = 1'b1;
      end else begin
        run_s = 1'b0;
      end
    end
  end
`else
  assign zb_s = 8'h00;
`endif

  seg_decode u_decode (
    .nibble  (frame_data_s[{idx_r, 2'b00} +: 4]),
    .dp      (frame_dp_s[idx_r]),
    .blank   (frame_blank_s[idx_r] | zb_s[idx_r]),
    .pattern (pattern_s)
  );

  // Tick counter, scan index, output handshake and frame shadow registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r       <= '0;
      idx_r       <= '0;
      data_sh_r   <= 32'h0000_0000;
      dp_sh_r     <= 8'h00;
      blank_sh_r  <= 8'h00;
      frame_r     <= '{seg: SEG_OFF, sel: 8'hFF};
      out_valid_r <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      cnt_r <= tick_s ? '0 : cnt_r + CW'(1);
      if (load_s) begin
        frame_r.seg <= pattern_s;
        frame_r.sel <= ~(8'b1 << idx_r);
        out_valid_r <= 1'b1;
        idx_r       <= idx_r + IW'(1);
        if (idx_r == '0) begin
          data_sh_r  <= data;
          dp_sh_r    <= dp;
          blank_sh_r <= blank;
        end
      end else if (xfer_s) begin
        out_valid_r <= 1'b0;
      end
      if (tick_s && out_valid_r && !out_ready) begin
        overrun_r <= 1'b1;
      end
    end
  end

  assign seg       = frame_r.seg;
  assign sel       = frame_r.sel;
  assign out_valid = out_valid_r;
  assign overrun   = overrun_r;

endmodule

// File: tb/tb_seg_scan.sv
// Self-checking bench for seg_scan (SCAN_DIV=4) against a frame-level reference model.
module tb_seg_scan;

  typedef struct {
    logic [7:0] seg;
    logic [7:0] sel;
  } fr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] data = 32'h0;
  logic [7:0]  dp = 8'h00;
  logic [7:0]  blank = 8'h00;
  logic        out_ready = 1'b1;
  logic [7:0]  seg, sel;
  logic        out_valid, overrun;

  int checks = 0;
  int errors = 0;

  logic [7:0] hex_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  // reference model state
  bit          m_valid, m_ovr;
  logic [7:0]  m_seg, m_sel;
  int          m_idx, m_k;
  logic [31:0] sh_data;
  logic [7:0]  sh_dp, sh_blank;
  fr_t         frames_q[$];

  seg_scan #(.SCAN_DIV(4), .DIGITS(8)) dut (
    .clk(clk), .rst(rst), .data(data), .dp(dp), .blank(blank),
    .out_ready(out_ready), .seg(seg), .sel(sel),
    .out_valid(out_valid), .overrun(overrun)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] exp_seg(logic [31:0] d, logic [7:0] p, logic [7:0] b, int i);
    bit dark;
    dark = b[i];
`ifdef SEG_SCAN_ZERO_BLANK_EN
    // digit i and everything above it are zero with no decimal point
    if (i > 0 && (d >> (4 * i)) == 32'h0 && (p >> i) == 8'h00) dark = 1'b1;
`endif
    if (dark) return 8'hFF;
    return hex_tab[(d >> (4 * i)) & 32'hF] & (p[i] ? 8'h7F : 8'hFF);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_ovr = 0; m_seg = 8'hFF; m_sel = 8'hFF;
    m_idx = 0; m_k = 0; sh_data = 32'h0; sh_dp = 8'h00; sh_blank = 8'h00;
  endtask

  task automatic model_step();
    bit tick, xfer;
    fr_t f;
    tick = (m_k % 4) == 3;
    xfer = m_valid && out_ready;
    m_k++;
    if (tick && m_valid && !out_ready) m_ovr = 1;
    if (tick && (!m_valid || xfer)) begin
      if (m_idx == 0) begin
        sh_data = data; sh_dp = dp; sh_blank = blank;
      end
      m_seg = exp_seg(sh_data, sh_dp, sh_blank, m_idx);
      m_sel = 8'hFF ^ (8'h01 << m_idx);
      m_valid = 1;
      m_idx = (m_idx + 1) % 8;
      f.seg = m_seg; f.sel = m_sel;
      frames_q.push_back(f);
    end else if (xfer) begin
      m_valid = 0;
    end
  endtask

  task automatic compare_all();
    chk("seg", seg, m_seg);
    chk("sel", sel, m_sel);
    chk("out_valid", out_valid, m_valid);
    chk("overrun", overrun, m_ovr);
  endtask

  task automatic cycle();
    @(posedge clk);
    if (!rst) model_step();
    #1 compare_all();
  endtask

  task automatic timeout(string name);
    checks++; errors++;
    $display("FAIL %s: timeout waiting, got none expected event", name);
  endtask

  task automatic wait_frames(int n, string name);
    int b = 0;
    while (frames_q.size() < n && b < 300) begin cycle(); b++; end
    if (frames_q.size() < n) timeout(name);
  endtask

  task automatic wait_sel(logic [7:0] s, string name);
    int start = frames_q.size();
    int b = 0;
    while (!(frames_q.size() > start && frames_q[$].sel == s) && b < 400) begin cycle(); b++; end
    if (!(frames_q.size() > start && frames_q[$].sel == s)) timeout(name);
  endtask

  initial begin
    int base;
    logic [7:0] held_seg, held_sel;
    bit have;
    logic [7:0] exp31 [8] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8};

    model_reset();
    cycle(); cycle();
    chk("rst_seg", seg, 8'hFF);
    chk("rst_sel", sel, 8'hFF);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_overrun", overrun, 1'b0);
    rst = 1'b0;

    // scan order with out_ready high
    data = 32'h76543210; dp = 8'h00; blank = 8'h00; out_ready = 1'b1;
    wait_frames(9, "scan_order");
    if (frames_q.size() >= 9) begin
      for (int i = 0; i < 8; i++) begin
        chk($sformatf("scan_seg%0d", i), frames_q[i].seg, exp31[i]);
        chk($sformatf("scan_sel%0d", i), frames_q[i].sel, 8'hFF ^ (8'h01 << i));
      end
      chk("scan_wrap_sel", frames_q[8].sel, 8'hFE);
    end

    // stall across a tick
    out_ready = 1'b0; have = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (out_valid) begin
        if (!have) begin held_seg = seg; held_sel = sel; have = 1; end
        else begin
          chk("stall_seg_stable", seg, held_seg);
          chk("stall_sel_stable", sel, held_sel);
        end
      end
    end
    chk("stall_overrun", overrun, 1'b1);
    chk("stall_model_overrun", m_ovr, 1'b1);
    out_ready = 1'b1;

    // shadow capture: no tearing mid-frame
    data = 32'h11111111;
    wait_sel(8'hFE, "tear_digit0");
    wait_sel(8'hF7, "tear_digit3");
    data = 32'h22222222;
    base = frames_q.size();
    wait_frames(base + 5, "tear_frames");
    if (frames_q.size() >= base + 5) begin
      for (int i = 0; i < 4; i++) chk($sformatf("tear_old%0d", i + 4), frames_q[base + i].seg, 8'hF9);
      chk("tear_new0", frames_q[base + 4].seg, 8'hA4);
    end

    // reset in the middle of a pending frame
    out_ready = 1'b0;
    for (int b = 0; b < 20 && !out_valid; b++) cycle();
    chk("pre_rst_valid", out_valid, 1'b1);
    rst = 1'b1;
    #1;
    model_reset();
    chk("async_seg", seg, 8'hFF);
    chk("async_sel", sel, 8'hFF);
    chk("async_valid", out_valid, 1'b0);
    chk("async_overrun", overrun, 1'b0);
    cycle();
    rst = 1'b0; out_ready = 1'b1;
    base = frames_q.size();
    wait_frames(base + 1, "post_rst_frame");
    chk("post_rst_sel", sel, 8'hFE);
    if (frames_q.size() > base) chk("post_rst_model_sel", frames_q[base].sel, 8'hFE);

    // leading-zero handling
    data = 32'h00000705; dp = 8'h00;
    wait_sel(8'hFE, "lz_digit0");
    base = frames_q.size() - 1;
    wait_frames(base + 8, "lz_frames");
    if (base >= 0 && frames_q.size() >= base + 8) begin
      chk("lz_d0", frames_q[base].seg, 8'h92);
      chk("lz_d1", frames_q[base + 1].seg, 8'hC0);
      chk("lz_d2", frames_q[base + 2].seg, 8'hF8);
      for (int i = 3; i < 8; i++) begin
`ifdef SEG_SCAN_ZERO_BLANK_EN
        chk($sformatf("lz_d%0d", i), frames_q[base + i].seg, 8'hFF);
`else
        chk($sformatf("lz_d%0d", i), frames_q[base + i].seg, 8'hC0);
`endif
      end
    end

    // blank wins over dp
    data = 32'h00000008; blank = 8'h01; dp = 8'h01;
    wait_sel(8'hFE, "blank_digit0");
    chk("blank_dp_model", frames_q[$].seg, 8'hFF);
    chk("blank_dp_dut", seg, 8'hFF);

    // randomized traffic
    for (int n = 0; n < 900; n++) begin
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 149) == 0) begin
        rst = 1'b1;
        #1;
        model_reset();
        compare_all();
      end
      if ($urandom_range(0, 15) == 0) begin
        data = $urandom >> (4 * $urandom_range(0, 8));
        dp = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
        blank = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
